// File: rtl/tpu_tile_scheduler.sv
// Tile sequencer for one 4x4 systolic array: streams A/B tiles in, accumulates over K, writes C tiles out.
// Optional build macro SCHED_TIMEOUT_EN adds a WAIT watchdog that abandons the command and raises err.
//   state | meaning
//   IDLE  | waiting for a command
//   LOAD  | 4 row reads, captured one cycle later (5 cycles)
//   START | one-cycle sa_start pulse
//   WAIT  | waiting for sa_done
//   ACC   | fold sa_c* into the accumulator (load on kt=0)
//   WRITE | 4 C row writes, then advance nt/mt
//   FIN   | done pulse, busy low
module tpu_tile_scheduler #(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_BITS  = 32,
  parameter int DATAC_BITS = 128,
  parameter int TILE_BITS  = 8
`ifdef SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [TILE_BITS-1:0]  m_tiles,
  input  logic [TILE_BITS-1:0]  k_tiles,
  input  logic [TILE_BITS-1:0]  n_tiles,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_BITS-1:0]  a_addr,
  input  logic [DATA_BITS-1:0]  a_data,
  output logic [ADDR_BITS-1:0]  b_addr,
  input  logic [DATA_BITS-1:0]  b_data,
  output logic                  c_wen,
  output logic [ADDR_BITS-1:0]  c_addr,
  output logic [DATAC_BITS-1:0] c_data,
  output logic                  sa_start,
  input  logic                  sa_done,
  output logic [DATA_BITS-1:0]  sa_a0,
  output logic [DATA_BITS-1:0]  sa_a1,
  output logic [DATA_BITS-1:0]  sa_a2,
  output logic [DATA_BITS-1:0]  sa_a3,
  output logic [DATA_BITS-1:0]  sa_b0,
  output logic [DATA_BITS-1:0]  sa_b1,
  output logic [DATA_BITS-1:0]  sa_b2,
  output logic [DATA_BITS-1:0]  sa_b3,
  input  logic [DATAC_BITS-1:0] sa_c0,
  input  logic [DATAC_BITS-1:0] sa_c1,
  input  logic [DATAC_BITS-1:0] sa_c2,
  input  logic [DATAC_BITS-1:0] sa_c3
);
  localparam int LANES = DATAC_BITS / 32;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, ACC, WRITE, FIN} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [TILE_BITS-1:0]  m_q, m_d, k_q, k_d, n_q, n_d;
  logic [TILE_BITS-1:0]  mt_q, mt_d, nt_q, nt_d, kt_q, kt_d;
  logic [DATA_BITS-1:0]  sa_a_q [4], sa_a_d [4], sa_b_q [4], sa_b_d [4];
  logic [DATAC_BITS-1:0] acc_q [4], acc_d [4], sa_c [4];
  logic [ADDR_BITS-1:0]  a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic [DATAC_BITS-1:0] c_data_q, c_data_d;
  logic                  busy_q, busy_d, done_q, done_d, c_wen_q, c_wen_d, sa_start_q, sa_start_d;
  logic                  accept, timeout;

  assign sa_c[0] = sa_c0;
  assign sa_c[1] = sa_c1;
  assign sa_c[2] = sa_c2;
  assign sa_c[3] = sa_c3;
  assign accept  = (state_q == IDLE) && in_valid;

  function automatic logic [ADDR_BITS-1:0] tile_addr(input logic [TILE_BITS-1:0] outer,
                                                     input logic [TILE_BITS-1:0] stride,
                                                     input logic [TILE_BITS-1:0] inner,
                                                     input logic [1:0]           r);
    return ((ADDR_BITS'(outer) * ADDR_BITS'(stride) + ADDR_BITS'(inner)) << 2) + ADDR_BITS'(r);
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    k_d      = k_q;
    n_d      = n_q;
    mt_d     = mt_q;
    nt_d     = nt_q;
    kt_d     = kt_q;
    sa_a_d   = sa_a_q;
    sa_b_d   = sa_b_q;
    acc_d    = acc_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_addr_d = c_addr_q;
    c_data_d = c_data_q;
    case (state_q)
      IDLE: if (in_valid) begin
        m_d   = m_tiles;
        k_d   = k_tiles;
        n_d   = n_tiles;
        mt_d  = '0;
        nt_d  = '0;
        kt_d  = '0;
        cnt_d = '0;
        acc_d = '{default: '0};
        if (m_tiles == '0 || k_tiles == '0 || n_tiles == '0) state_d = FIN;
        else state_d = LOAD;
      end
      LOAD: begin
        // read data lags the address by one cycle, so row r lands in cycle r+1
        if (cnt_q != 3'd0) begin
          sa_a_d[2'(cnt_q - 3'd1)] = a_data;
          sa_b_d[2'(cnt_q - 3'd1)] = b_data;
        end
        if (cnt_q == 3'd4) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (sa_done) state_d = ACC;
        else if (timeout) state_d = FIN;
      end
      ACC: begin
        for (int r = 0; r < 4; r++)
          for (int l = 0; l < LANES; l++)
            acc_d[r][32*l +: 32] = (kt_q == '0 ? 32'd0 : acc_q[r][32*l +: 32]) + sa_c[r][32*l +: 32];
        cnt_d = '0;
        if (kt_q != k_q - TILE_BITS'(1)) begin
          kt_d    = kt_q + TILE_BITS'(1);
          state_d = LOAD;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (cnt_q == 3'd3) begin
          cnt_d   = '0;
          kt_d    = '0;
          state_d = LOAD;
          if (nt_q != n_q - TILE_BITS'(1)) begin
            nt_d = nt_q + TILE_BITS'(1);
          end else begin
            nt_d = '0;
            if (mt_q != m_q - TILE_BITS'(1)) mt_d = mt_q + TILE_BITS'(1);
            else state_d = FIN;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they are prepared from the next-cycle state and counters
    if (state_d == LOAD && cnt_d < 3'd4) begin
      a_addr_d = tile_addr(mt_d, k_d, kt_d, cnt_d[1:0]);
      b_addr_d = tile_addr(kt_d, n_d, nt_d, cnt_d[1:0]);
    end
    if (state_d == WRITE) begin
      c_addr_d = tile_addr(mt_d, n_d, nt_d, cnt_d[1:0]);
      c_data_d = acc_d[cnt_d[1:0]];
    end
    busy_d     = state_d inside {LOAD, START, WAIT, ACC, WRITE};
    done_d     = (state_d == FIN);
    c_wen_d    = (state_d == WRITE);
    sa_start_d = (state_d == START);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      m_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      mt_q       <= '0;
      nt_q       <= '0;
      kt_q       <= '0;
      sa_a_q     <= '{default: '0};
      sa_b_q     <= '{default: '0};
      acc_q      <= '{default: '0};
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      c_addr_q   <= '0;
      c_data_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      c_wen_q    <= 1'b0;
      sa_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      m_q        <= m_d;
      k_q        <= k_d;
      n_q        <= n_d;
      mt_q       <= mt_d;
      nt_q       <= nt_d;
      kt_q       <= kt_d;
      sa_a_q     <= sa_a_d;
      sa_b_q     <= sa_b_d;
      acc_q      <= acc_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      c_addr_q   <= c_addr_d;
      c_data_q   <= c_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      c_wen_q    <= c_wen_d;
      sa_start_q <= sa_start_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int TMR_BITS = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_BITS-1:0] tmr_q, tmr_d;
  logic                err_q, err_d;

  // loaded one short so the done pulse lands TIMEOUT_CYC cycles after sa_start
  always_comb begin
    tmr_d = tmr_q;
    err_d = err_q;
    if (state_d == START) tmr_d = TMR_BITS'(TIMEOUT_CYC - 1);
    else if (tmr_q != '0) tmr_d = tmr_q - TMR_BITS'(1);
    if (accept) err_d = 1'b0;
    if (state_q == WAIT && !sa_done && timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign timeout = (tmr_q == '0);
  assign err     = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign c_wen    = c_wen_q;
  assign sa_start = sa_start_q;
  assign a_addr   = a_addr_q;
  assign b_addr   = b_addr_q;
  assign c_addr   = c_addr_q;
  assign c_data   = c_data_q;
  assign sa_a0    = sa_a_q[0];
  assign sa_a1    = sa_a_q[1];
  assign sa_a2    = sa_a_q[2];
  assign sa_a3    = sa_a_q[3];
  assign sa_b0    = sa_b_q[0];
  assign sa_b1    = sa_b_q[1];
  assign sa_b2    = sa_b_q[2];
  assign sa_b3    = sa_b_q[3];
endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Scoreboard bench for tpu_tile_scheduler: buffer models, a systolic-array model, and queued expectations.
module tb_tpu_tile_scheduler;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   m_tiles = '0, k_tiles = '0, n_tiles = '0;
  logic         busy, done, err, c_wen, sa_start;
  logic [15:0]  a_addr, b_addr, c_addr;
  logic [31:0]  a_data = '0, b_data = '0;
  logic [127:0] c_data;
  logic         sa_done = 1'b0;
  logic [31:0]  sa_a0, sa_a1, sa_a2, sa_a3, sa_b0, sa_b1, sa_b2, sa_b3;
  logic [127:0] sa_c0 = '0, sa_c1 = '0, sa_c2 = '0, sa_c3 = '0;

  tpu_tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .m_tiles(m_tiles), .k_tiles(k_tiles), .n_tiles(n_tiles),
    .busy(busy), .done(done), .err(err),
    .a_addr(a_addr), .a_data(a_data), .b_addr(b_addr), .b_data(b_data),
    .c_wen(c_wen), .c_addr(c_addr), .c_data(c_data),
    .sa_start(sa_start), .sa_done(sa_done),
    .sa_a0(sa_a0), .sa_a1(sa_a1), .sa_a2(sa_a2), .sa_a3(sa_a3),
    .sa_b0(sa_b0), .sa_b1(sa_b1), .sa_b2(sa_b2), .sa_b3(sa_b3),
    .sa_c0(sa_c0), .sa_c1(sa_c1), .sa_c2(sa_c2), .sa_c3(sa_c3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // global buffers with one-cycle read latency
  logic [31:0] amem [256];
  logic [31:0] bmem [256];
  always @(posedge clk) begin
    a_data <= amem[a_addr[7:0]];
    b_data <= bmem[b_addr[7:0]];
  end

  // systolic array model: done sa_delay cycles after start; product or constant lanes
  int          sa_delay = 2;
  int          sa_cnt = 0;
  bit          sa_hold = 1'b0;
  bit          prod_mode = 1'b0;
  logic [31:0] cval = 32'd1;

  function automatic logic [127:0] row_prod(input logic [31:0] a, input logic [31:0] b0,
                                            input logic [31:0] b1, input logic [31:0] b2,
                                            input logic [31:0] b3);
    logic [31:0]  br [4];
    logic [127:0] res;
    int           s;
    br[0] = b0; br[1] = b1; br[2] = b2; br[3] = b3;
    res = '0;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += $signed(a[31-8*k -: 8]) * $signed(br[k][31-8*j -: 8]);
      res[127-32*j -: 32] = s;
    end
    return res;
  endfunction

  always @(posedge clk) begin
    sa_done <= 1'b0;
    if (sa_cnt > 0) begin
      sa_cnt <= sa_cnt - 1;
      if (sa_cnt == 1) begin
        sa_done <= 1'b1;
        sa_c0 <= prod_mode ? row_prod(sa_a0, sa_b0, sa_b1, sa_b2, sa_b3) : {4{cval}};
        sa_c1 <= prod_mode ? row_prod(sa_a1, sa_b0, sa_b1, sa_b2, sa_b3) : {4{cval}};
        sa_c2 <= prod_mode ? row_prod(sa_a2, sa_b0, sa_b1, sa_b2, sa_b3) : {4{cval}};
        sa_c3 <= prod_mode ? row_prod(sa_a3, sa_b0, sa_b1, sa_b2, sa_b3) : {4{cval}};
      end
    end else if (sa_start && !sa_hold) begin
      sa_cnt <= sa_delay;
    end
  end

  typedef struct packed {logic [15:0] addr; logic [127:0] data; logic [7:0] starts;} wr_t;
  typedef struct packed {logic [127:0] a; logic [127:0] b;} st_t;
  typedef struct packed {logic err; int lat;} dn_t;
  wr_t wq[$];
  st_t sq[$];
  dn_t dq[$];
  wr_t we;
  st_t se;
  dn_t de;

  int checks = 0, errors = 0;
  int start_seen = 0, done_seen = 0, starts_cmd = 0, start_cyc = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // monitor: pops expectations whenever the DUT presents a start, a write or a done
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      starts_cmd = 0;
    end else begin
      if (sa_start) begin
        start_seen++;
        starts_cmd++;
        start_cyc = cyc;
        if (sq.size() == 0) fail_now("unexpected_sa_start");
        else begin
          se = sq.pop_front();
          check("sa_a_rows", {sa_a3, sa_a2, sa_a1, sa_a0}, se.a);
          check("sa_b_rows", {sa_b3, sa_b2, sa_b1, sa_b0}, se.b);
        end
      end
      if (c_wen) begin
        if (wq.size() == 0) fail_now("unexpected_c_wen");
        else begin
          we = wq.pop_front();
          check("c_addr", c_addr, we.addr);
          check("c_data", c_data, we.data);
          check("starts_before_write", starts_cmd, we.starts);
        end
      end
      if (done) begin
        done_seen++;
        check("busy_at_done", busy, 0);
        if (dq.size() == 0) fail_now("unexpected_done");
        else begin
          de = dq.pop_front();
          check("err_at_done", err, de.err);
          if (de.lat >= 0) check("timeout_latency", cyc - start_cyc, de.lat);
        end
        starts_cmd = 0;
      end
      if (done && done_prev) fail_now("done_longer_than_one_cycle");
    end
    done_prev = done;
  end

  task automatic push_tags(input int ab, input int bb);
    st_t s;
    for (int r = 0; r < 4; r++) begin
      s.a[32*r +: 32] = 32'hA000_0000 + 32'(ab + r);
      s.b[32*r +: 32] = 32'hB000_0000 + 32'(bb + r);
    end
    sq.push_back(s);
  endtask

  task automatic push_writes(input int base, input logic [127:0] row, input int starts);
    wr_t w;
    for (int r = 0; r < 4; r++) begin
      w.addr = 16'(base + r);
      w.data = row;
      w.starts = 8'(starts);
      wq.push_back(w);
    end
  endtask

  task automatic push_done(input logic e, input int lat);
    dn_t d;
    d.err = e;
    d.lat = lat;
    dq.push_back(d);
  endtask

  task automatic issue(input int m, input int k, input int n);
    @(negedge clk);
    in_valid = 1'b1;
    m_tiles = 8'(m);
    k_tiles = 8'(k);
    n_tiles = 8'(n);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_for_done(input int target, input int budget, input string name);
    for (int i = 0; i < budget && done_seen < target; i++) @(negedge clk);
    if (done_seen < target) fail_now(name);
  endtask

  task automatic run(input int m, input int k, input int n, input int budget, input string name);
    int target;
    target = done_seen + 1;
    issue(m, k, n);
    wait_for_done(target, budget, name);
    repeat (2) @(negedge clk);
    check("queues_drained", 128'(wq.size() + sq.size() + dq.size()), 0);
  endtask

  task automatic tag_mem();
    for (int i = 0; i < 256; i++) begin
      amem[i] = 32'hA000_0000 + 32'(i);
      bmem[i] = 32'hB000_0000 + 32'(i);
    end
  endtask

  initial begin
    int target;
    tag_mem();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_c_wen", c_wen, 0);
    check("rst_sa_start", sa_start, 0);
    check("rst_addrs", {a_addr, b_addr, c_addr}, 0);
    check("rst_c_data", c_data, 0);
    check("rst_sa_rows", {sa_a0, sa_a1, sa_a2, sa_a3, sa_b0, sa_b1, sa_b2, sa_b3}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // identity A times B rows 0x01020304 -> every C row lanes 1,2,3,4
    amem[0] = 32'h0100_0000; amem[1] = 32'h0001_0000; amem[2] = 32'h0000_0100; amem[3] = 32'h0000_0001;
    for (int i = 0; i < 4; i++) bmem[i] = 32'h0102_0304;
    prod_mode = 1'b1;
    sq.push_back('{a: {32'h0000_0001, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000},
                   b: {4{32'h0102_0304}}});
    push_writes(0, 128'h00000001_00000002_00000003_00000004, 1);
    push_done(1'b0, -1);
    run(1, 1, 1, 200, "timeout_identity");
    prod_mode = 1'b0;
    tag_mem();

    // k=2, ones per pass -> lanes 2, written after the second start
    cval = 32'd1;
    push_tags(0, 0); push_tags(4, 4);
    push_writes(0, {4{32'd2}}, 2);
    push_done(1'b0, -1);
    run(1, 2, 1, 200, "timeout_k2");

    // m=2 k=1 n=2 loop order, plus an in_valid while busy that must be ignored
    cval = 32'h5A;
    push_tags(0, 0); push_tags(0, 4); push_tags(4, 0); push_tags(4, 4);
    push_writes(0, {4{32'h5A}}, 1); push_writes(4, {4{32'h5A}}, 2);
    push_writes(8, {4{32'h5A}}, 3); push_writes(12, {4{32'h5A}}, 4);
    push_done(1'b0, -1);
    target = done_seen + 1;
    issue(2, 1, 2);
    repeat (3) @(negedge clk);
    in_valid = 1'b1; m_tiles = 8'd1; k_tiles = 8'd1; n_tiles = 8'd1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_for_done(target, 400, "timeout_m2n2");
    repeat (2) @(negedge clk);
    check("queues_drained", 128'(wq.size() + sq.size() + dq.size()), 0);

    // k=3 with 0x80000000 lanes wraps back to 0x80000000
    cval = 32'h8000_0000;
    push_tags(0, 0); push_tags(4, 4); push_tags(8, 8);
    push_writes(0, {4{32'h8000_0000}}, 3);
    push_done(1'b0, -1);
    run(1, 3, 1, 300, "timeout_wrap");

    // zero-size command: done only
    push_done(1'b0, -1);
    run(1, 1, 0, 20, "timeout_zero_size");

    // reset during WAIT, stray sa_done afterwards
    sa_delay = 10;
    push_tags(0, 0);
    target = start_seen + 1;
    issue(1, 1, 1);
    for (int i = 0; i < 50 && start_seen < target; i++) @(negedge clk);
    if (start_seen < target) fail_now("timeout_reset_start");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("busy_after_reset", busy, 0);
    check("c_wen_after_reset", c_wen, 0);
    repeat (20) @(negedge clk);
    check("busy_after_stray_done", busy, 0);
    sa_delay = 2;
    cval = 32'd7;
    push_tags(0, 0);
    push_writes(0, {4{32'd7}}, 1);
    push_done(1'b0, -1);
    run(1, 1, 1, 200, "timeout_after_reset");

`ifdef SCHED_TIMEOUT_EN
    sa_hold = 1'b1;
    push_tags(0, 0);
    push_done(1'b1, 255);
    run(1, 1, 1, 400, "timeout_watchdog");
    sa_hold = 1'b0;
    cval = 32'd3;
    push_tags(0, 0);
    push_writes(0, {4{32'd3}}, 1);
    push_done(1'b0, -1);
    run(1, 1, 1, 200, "timeout_err_clear");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end
endmodule
